// File: rtl/tgl_handshake_rx_if.sv
// Toggle-handshake receiver bus: remote toggle request/acknowledge plus the
// local valid/ready event port, error flag and accepted-event counter.
interface tgl_handshake_rx_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req_tgl;
  logic             ack_tgl;
  logic             evt_valid;
  logic             evt_ready;
  logic             clr_err;
  logic             proto_err;
  logic [CNT_W-1:0] evt_count;

  // Sender/consumer side: drives request, ready and error clear.
  modport master (
    output req_tgl,
    output evt_ready,
    output clr_err,
    input  ack_tgl,
    input  evt_valid,
    input  proto_err,
    input  evt_count
  );

  // Receiver side: the tgl_handshake_rx block.
  modport slave (
    input  req_tgl,
    input  evt_ready,
    input  clr_err,
    output ack_tgl,
    output evt_valid,
    output proto_err,
    output evt_count
  );
endinterface

// File: rtl/tgl_handshake_rx.sv
// Receiving end of a two-phase toggle handshake. The asynchronous req_tgl is
// synchronised, each toggle becomes one pending event on a valid/ready port,
// and every accept toggles ack_tgl back to the sender.
// Optional feature macro: TGL_EVT_COUNT_EN enables the accepted-event counter;
// without it evt_count is tied to zero.
module tgl_handshake_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input logic               Clk,
  input logic               rst,
  tgl_handshake_rx_if.slave hs
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e                 state_q;
  state_e                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_dly_q;
  logic                   tgl_det;
  logic                   pend;
  logic                   accept;
  logic                   viol;
  logic                   ack_q;
  logic                   ack_d;
  logic                   err_q;
  logic                   err_d;

  // Synchroniser chain and one-cycle delay for toggle detection.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      req_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], hs.req_tgl};
      req_dly_q <= req_s;
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign tgl_det = req_s ^ req_dly_q;

  // FSM state register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a toggle arriving on the accept cycle keeps the event pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tgl_det) state_d = PEND;
      PEND:    if (accept && !tgl_det) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept/violation decode and next values of the flag registers.
  always_comb begin
    pend   = (state_q == PEND);
    accept = pend & hs.evt_ready;
    viol   = pend & ~hs.evt_ready & tgl_det;
    ack_d  = ack_q ^ accept;
    err_d  = viol | (err_q & ~hs.clr_err);
  end

  // Acknowledge toggle and sticky protocol error; a new violation beats clr_err.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign hs.evt_valid = pend;
  assign hs.ack_tgl   = ack_q;
  assign hs.proto_err = err_q;

`ifdef TGL_EVT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Accepted-event counter, wraps modulo 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hs.evt_count = cnt_q;
`else
  assign hs.evt_count = '0;
`endif

endmodule

// File: tb/tb_tgl_handshake_rx.sv
// Directed self-checking bench for tgl_handshake_rx (counter width 4 for wrap).
module tb_tgl_handshake_rx;

  localparam int unsigned CNT_W = 4;
`ifdef TGL_EVT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic exp_ack = 1'b0;

  tgl_handshake_rx_if #(.CNT_W(CNT_W)) hs ();

  tgl_handshake_rx #(
    .SYNC_STAGES(2),
    .CNT_W      (CNT_W)
  ) dut (
    .Clk(clk),
    .rst(rst_n),
    .hs (hs)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] want_cnt();
    return CNT_EN ? exp_cnt : '0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic toggle();
    hs.req_tgl = ~hs.req_tgl;
  endtask

  task automatic test_reset();
    hs.req_tgl = 1'b0; hs.evt_ready = 1'b0; hs.clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", hs.ack_tgl); end
    total++; if (hs.proto_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", hs.proto_err); end
    total++; if (hs.evt_count !== '0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", hs.evt_count); end
    rst_n = 1'b1;
    repeat (2) cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid: got %b want 0", hs.evt_valid); end
  endtask

  task automatic test_single();
    toggle(); hs.evt_ready = 1'b1;
    cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL single_e1: got %b want 0", hs.evt_valid); end
    cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL single_e2: got %b want 0", hs.evt_valid); end
    cyc();
    total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL single_e3: got %b want 1", hs.evt_valid); end
    total++; if (hs.ack_tgl !== 1'b0) begin bad++; $display("FAIL single_ack_e3: got %b want 0", hs.ack_tgl); end
    cyc();
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL single_e4: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL single_ack: got %b want %b", hs.ack_tgl, exp_ack); end
    total++; if (hs.evt_count !== want_cnt()) begin bad++; $display("FAIL single_cnt: got %0d want %0d", hs.evt_count, want_cnt()); end
  endtask

  task automatic test_backpressure();
    toggle(); hs.evt_ready = 1'b0;
    repeat (3) cyc();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) cyc();
      total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d]: got %b want 1", i, hs.evt_valid); end
      total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL bp_ack[%0d]: got %b want %b", i, hs.ack_tgl, exp_ack); end
    end
    hs.evt_ready = 1'b1;
    cyc();
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL bp_ack_flip: got %b want %b", hs.ack_tgl, exp_ack); end
    cyc();
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL bp_ack_once: got %b want %b", hs.ack_tgl, exp_ack); end
    total++; if (hs.evt_count !== want_cnt()) begin bad++; $display("FAIL bp_cnt: got %0d want %0d", hs.evt_count, want_cnt()); end
  endtask

  task automatic test_back_to_back();
    logic ack0;
    ack0 = exp_ack;
    toggle(); hs.evt_ready = 1'b1;
    cyc();
    toggle();
    repeat (2) cyc();
    total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b want 1", hs.evt_valid); end
    cyc();
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
    total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL b2b_stay: got %b want 1", hs.evt_valid); end
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL b2b_ack1: got %b want %b", hs.ack_tgl, exp_ack); end
    cyc();
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL b2b_done: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== ack0) begin bad++; $display("FAIL b2b_ack2: got %b want %b", hs.ack_tgl, ack0); end
    total++; if (hs.proto_err !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", hs.proto_err); end
    total++; if (hs.evt_count !== want_cnt()) begin bad++; $display("FAIL b2b_cnt: got %0d want %0d", hs.evt_count, want_cnt()); end
  endtask

  task automatic test_violation();
    toggle(); hs.evt_ready = 1'b0;
    repeat (3) cyc();
    total++; if (hs.proto_err !== 1'b0) begin bad++; $display("FAIL viol_pre: got %b want 0", hs.proto_err); end
    toggle();
    repeat (2) cyc();
    toggle();
    cyc();
    total++; if (hs.proto_err !== 1'b1) begin bad++; $display("FAIL viol_set: got %b want 1", hs.proto_err); end
    cyc();
    hs.clr_err = 1'b1;
    cyc();
    total++; if (hs.proto_err !== 1'b1) begin bad++; $display("FAIL viol_set_wins: got %b want 1", hs.proto_err); end
    total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL viol_hold: got %b want 1", hs.evt_valid); end
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL viol_ack_hold: got %b want %b", hs.ack_tgl, exp_ack); end
    cyc();
    total++; if (hs.proto_err !== 1'b0) begin bad++; $display("FAIL viol_clr: got %b want 0", hs.proto_err); end
    hs.clr_err = 1'b0; hs.evt_ready = 1'b1;
    cyc();
    exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL viol_acc: got %b want 0", hs.evt_valid); end
    repeat (3) cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL viol_one_evt: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== exp_ack) begin bad++; $display("FAIL viol_ack: got %b want %b", hs.ack_tgl, exp_ack); end
    total++; if (hs.evt_count !== want_cnt()) begin bad++; $display("FAIL viol_cnt: got %0d want %0d", hs.evt_count, want_cnt()); end
  endtask

  task automatic test_reset_mid();
    toggle(); hs.evt_ready = 1'b0;
    repeat (3) cyc();
    total++; if (hs.evt_valid !== 1'b1) begin bad++; $display("FAIL rmid_pend: got %b want 1", hs.evt_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", hs.evt_valid); end
    total++; if (hs.ack_tgl !== 1'b0) begin bad++; $display("FAIL rmid_ack: got %b want 0", hs.ack_tgl); end
    total++; if (hs.proto_err !== 1'b0) begin bad++; $display("FAIL rmid_err: got %b want 0", hs.proto_err); end
    total++; if (hs.evt_count !== '0) begin bad++; $display("FAIL rmid_cnt: got %0d want 0", hs.evt_count); end
    hs.req_tgl = 1'b0;
    exp_ack = 1'b0; exp_cnt = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    total++; if (hs.evt_valid !== 1'b0) begin bad++; $display("FAIL rmid_lost: got %b want 0", hs.evt_valid); end
  endtask

  task automatic test_wrap();
    hs.evt_ready = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      toggle();
      repeat (4) cyc();
      exp_ack = ~exp_ack; exp_cnt = exp_cnt + 4'd1;
      total++; if (hs.evt_count !== want_cnt()) begin bad++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", n, hs.evt_count, want_cnt()); end
    end
    total++; if (hs.ack_tgl !== 1'b1) begin bad++; $display("FAIL wrap_ack: got %b want 1", hs.ack_tgl); end
    total++; if (hs.evt_count !== (CNT_EN ? 4'd1 : 4'd0)) begin bad++; $display("FAIL wrap_final: got %0d want %0d", hs.evt_count, CNT_EN ? 1 : 0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_violation();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
